// File: rtl/core_pkg.sv
// Shared core types and sizing for the reservation station.
// Optional build macro: RS_AGE_SELECT_EN adds a per-entry age used for oldest-first select.
package core_pkg;

    localparam int FETCH_WIDTH = 2;
    localparam int LOG2_PREGS  = 6;
    localparam int RS_ENTRIES  = 16;
    localparam int CDB_PORTS   = 2;
    localparam int RS_VAL_W    = 64;
    localparam int RS_AGE_W    = $clog2(RS_ENTRIES);

    // Entry storage is sized by the core-wide tag and operand widths.
    typedef struct packed {
        logic                  valid;
        logic [7:0]            op;
        logic [LOG2_PREGS-1:0] dst_tag;
        logic [LOG2_PREGS-1:0] src1_tag;
        logic [RS_VAL_W-1:0]   src1_val;
        logic                  src1_ready;
        logic [LOG2_PREGS-1:0] src2_tag;
        logic [RS_VAL_W-1:0]   src2_val;
        logic                  src2_ready;
        logic [5:0]            rob_tag;
`ifdef RS_AGE_SELECT_EN
        logic [RS_AGE_W-1:0]   age;
`endif
    } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Issue picker: lowest-index eligible entry, or oldest eligible entry when
// RS_AGE_SELECT_EN is defined (ties resolve to the lowest index).
module rs_select #(
    parameter int N = 16
`ifdef RS_AGE_SELECT_EN
    ,
    parameter int AGE_W = 4
`endif
) (
    input  logic [N-1:0]            eligible,
`ifdef RS_AGE_SELECT_EN
    input  logic [N-1:0][AGE_W-1:0] age,
`endif
    output logic [N-1:0]            grant,
    output logic [$clog2(N)-1:0]    index
);

    logic found;
`ifdef RS_AGE_SELECT_EN
    logic [AGE_W-1:0] best_age;
`endif

    // Strict compare on age keeps the earliest index on a tie.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
`ifdef RS_AGE_SELECT_EN
        best_age = '0;
`endif
        for (int i = 0; i < N; i++) begin
`ifdef RS_AGE_SELECT_EN
            if (eligible[i] && (!found || age[i] > best_age)) begin
                found    = 1'b1;
                best_age = age[i];
                index    = ($clog2(N))'(i);
            end
`else
            if (eligible[i] && !found) begin
                found = 1'b1;
                index = ($clog2(N))'(i);
            end
`endif
        end
        if (found) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: multi-lane allocate, dual CDB wakeup, single issue.
// Optional build macro: RS_AGE_SELECT_EN selects the oldest ready entry instead of the lowest index.
module reservation_station #(
    parameter int FETCH_W    = core_pkg::FETCH_WIDTH,
    parameter int RS_ENTRIES = core_pkg::RS_ENTRIES,
    parameter int PHYS_W     = core_pkg::LOG2_PREGS,
    parameter int VAL_W      = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [FETCH_W-1:0]             rs_alloc_en,
    input  logic [FETCH_W-1:0][PHYS_W-1:0] rs_alloc_dst_tag,
    input  logic [FETCH_W-1:0][PHYS_W-1:0] rs_alloc_src1_tag,
    input  logic [FETCH_W-1:0][PHYS_W-1:0] rs_alloc_src2_tag,
    input  logic [FETCH_W-1:0][VAL_W-1:0]  rs_alloc_src1_val,
    input  logic [FETCH_W-1:0][VAL_W-1:0]  rs_alloc_src2_val,
    input  logic [FETCH_W-1:0]             rs_alloc_src1_ready,
    input  logic [FETCH_W-1:0]             rs_alloc_src2_ready,
    input  logic [FETCH_W-1:0][7:0]        rs_alloc_op,
    input  logic [FETCH_W-1:0][5:0]        rs_alloc_rob_tag,
    output logic                           rs_full,
    input  logic [1:0]                     cdb_valid,
    input  logic [1:0][PHYS_W-1:0]         cdb_tag,
    input  logic [1:0][VAL_W-1:0]          cdb_value,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [7:0]                     issue_op,
    output logic [PHYS_W-1:0]              issue_dst_tag,
    output logic [VAL_W-1:0]               issue_src1_val,
    output logic [VAL_W-1:0]               issue_src2_val,
    output logic [5:0]                     issue_rob_tag,
    output logic [$clog2(RS_ENTRIES):0]    rs_count
);

    import core_pkg::*;

    localparam int IDX_W = $clog2(RS_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    rs_entry_t             entries      [RS_ENTRIES];
    rs_entry_t             entries_next [RS_ENTRIES];
    rs_entry_t             new_entry;
    logic [RS_ENTRIES-1:0] eligible;
    logic [RS_ENTRIES-1:0] grant;
    logic [RS_ENTRIES-1:0] taken;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      alloc_slot [FETCH_W];
    logic [FETCH_W-1:0]    alloc_ok;
    logic                  issue_fire;
    logic [CNT_W-1:0]      count_next;
`ifdef RS_AGE_SELECT_EN
    logic [RS_ENTRIES-1:0][RS_AGE_W-1:0] ages;
`endif

    // Later CDB ports overwrite earlier ones, so port 1 wins a double match.
    function automatic rs_entry_t wake(input rs_entry_t e, input logic [1:0] v,
                                       input logic [1:0][PHYS_W-1:0] tags,
                                       input logic [1:0][VAL_W-1:0] vals);
        wake = e;
        for (int j = 0; j < CDB_PORTS; j++) begin
            if (v[j] && !e.src1_ready && e.src1_tag == tags[j]) begin
                wake.src1_val   = vals[j];
                wake.src1_ready = 1'b1;
            end
            if (v[j] && !e.src2_ready && e.src2_tag == tags[j]) begin
                wake.src2_val   = vals[j];
                wake.src2_ready = 1'b1;
            end
        end
    endfunction

    assign rs_full    = (RS_ENTRIES - int'(rs_count)) < FETCH_W;
    assign alloc_ok   = rs_alloc_en & {FETCH_W{!rs_full}};
    assign issue_valid = |eligible;
    assign issue_fire = issue_valid && issue_ready;

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            eligible[i] = entries[i].valid && entries[i].src1_ready && entries[i].src2_ready;
`ifdef RS_AGE_SELECT_EN
            ages[i] = entries[i].age;
`endif
        end
    end

    rs_select #(
        .N     (RS_ENTRIES)
`ifdef RS_AGE_SELECT_EN
        ,
        .AGE_W (RS_AGE_W)
`endif
    ) u_select (
        .eligible (eligible),
`ifdef RS_AGE_SELECT_EN
        .age      (ages),
`endif
        .grant    (grant),
        .index    (sel_idx)
    );

    always_comb begin
        issue_op       = '0;
        issue_dst_tag  = '0;
        issue_src1_val = '0;
        issue_src2_val = '0;
        issue_rob_tag  = '0;
        if (issue_valid) begin
            issue_op       = entries[sel_idx].op;
            issue_dst_tag  = entries[sel_idx].dst_tag;
            issue_src1_val = entries[sel_idx].src1_val;
            issue_src2_val = entries[sel_idx].src2_val;
            issue_rob_tag  = entries[sel_idx].rob_tag;
        end
    end

    // Each enabled lane takes the lowest free slot not claimed by an earlier lane.
    always_comb begin
        taken = '0;
        for (int l = 0; l < FETCH_W; l++) begin
            alloc_slot[l] = '0;
            for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
                if (alloc_ok[l] && !entries[i].valid && !taken[i]) begin
                    alloc_slot[l] = IDX_W'(i);
                end
            end
            if (alloc_ok[l]) begin
                taken[alloc_slot[l]] = 1'b1;
            end
        end
    end

    always_comb begin
        new_entry = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            entries_next[i] = entries[i];
            if (entries[i].valid) begin
                entries_next[i] = wake(entries[i], cdb_valid, cdb_tag, cdb_value);
            end
            if (issue_fire && grant[i]) begin
                entries_next[i].valid = 1'b0;
            end
`ifdef RS_AGE_SELECT_EN
            if (|alloc_ok && entries_next[i].valid && entries_next[i].age != '1) begin
                entries_next[i].age = entries_next[i].age + 1'b1;
            end
`endif
        end
        for (int l = 0; l < FETCH_W; l++) begin
            if (alloc_ok[l]) begin
                new_entry            = '0;
                new_entry.valid      = 1'b1;
                new_entry.op         = rs_alloc_op[l];
                new_entry.dst_tag    = rs_alloc_dst_tag[l];
                new_entry.src1_tag   = rs_alloc_src1_tag[l];
                new_entry.src1_val   = rs_alloc_src1_val[l];
                new_entry.src1_ready = rs_alloc_src1_ready[l];
                new_entry.src2_tag   = rs_alloc_src2_tag[l];
                new_entry.src2_val   = rs_alloc_src2_val[l];
                new_entry.src2_ready = rs_alloc_src2_ready[l];
                new_entry.rob_tag    = rs_alloc_rob_tag[l];
                entries_next[alloc_slot[l]] = wake(new_entry, cdb_valid, cdb_tag, cdb_value);
            end
        end
        if (flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                entries_next[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        count_next = rs_count;
        for (int l = 0; l < FETCH_W; l++) begin
            if (alloc_ok[l]) begin
                count_next = count_next + CNT_W'(1);
            end
        end
        if (issue_fire) begin
            count_next = count_next - CNT_W'(1);
        end
        if (flush) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            rs_count <= '0;
        end else begin
            entries  <= entries_next;
            rs_count <= count_next;
        end
    end

    // Allocation attempts while full are dropped; flag them in simulation.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(rs_full && (|rs_alloc_en)))
            else $warning("reservation_station: allocation while rs_full was ignored");
        end
    end

endmodule
